uart_tx_arbiter: RTL

- Shares one uart_tx instance among NUM_REQ byte producers, e.g. a command responder, a status reporter and a debug streamer.
- Each requester offers bytes on a valid/ready handshake. A round-robin arbiter grants one byte at a time.
- The granted byte is presented to uart_tx as a one-cycle i_tx_valid pulse with tx_message. The arbiter then waits for uart_tx done before it arbitrates again.
- Sits between the application logic and uart_tx in the UART top level.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte producers
// Optional UART_ARB_PACKET_LOCK_EN: grant stays on one requester until its i_req_last byte completes.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 source_clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_message,
    input  logic                 i_tx_done,
    output logic                 o_busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   last_grant_q, last_grant_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [7:0]         tx_message_q, tx_message_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               tx_valid_q, tx_valid_d;

    logic               rr_found;
    logic [PTR_W-1:0]   rr_idx;
    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_onehot;

    // Search upward from last_grant+1 with wrap; the first valid requester wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand     = last_grant_q;
        rr_found = 1'b0;
        rr_idx   = last_grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == PTR_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!rr_found && i_req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef UART_ARB_PACKET_LOCK_EN
    logic lock_q, lock_d;
    logic cur_last_q, cur_last_d;

    // While locked, last_grant still names the packet owner because it is not advanced.
    always_comb begin
        if (lock_q) begin
            sel_valid = i_req_valid[last_grant_q];
            sel_idx   = last_grant_q;
        end else begin
            sel_valid = rr_found;
            sel_idx   = rr_idx;
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^i_req_last;
    assign sel_valid       = rr_found;
    assign sel_idx         = rr_idx;
`endif

    assign sel_onehot   = NUM_REQ'(1) << sel_idx;
    assign o_req_ready  = (state_q == IDLE && sel_valid && !rst) ? sel_onehot : '0;
    assign o_grant      = grant_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_tx_message = tx_message_q;
    assign o_busy       = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        tx_message_d = tx_message_q;
        grant_d      = grant_q;
        tx_valid_d   = 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
        lock_d       = lock_q;
        cur_last_d   = cur_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    tx_message_d = i_req_data[8*sel_idx +: 8];
                    grant_d      = sel_onehot;
                    last_grant_d = sel_idx;
                    tx_valid_d   = 1'b1;
                    state_d      = LAUNCH;
`ifdef UART_ARB_PACKET_LOCK_EN
                    cur_last_d   = i_req_last[sel_idx];
`endif
                end
            end
            LAUNCH: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (i_tx_done) begin
                    gap_cnt_d = 4'(GAP_CYCLES - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    grant_d = '0;
                    state_d = IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                    lock_d  = !cur_last_q;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge source_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PTR_W'(NUM_REQ - 1);
            gap_cnt_q    <= '0;
            tx_message_q <= 8'h00;
            grant_q      <= '0;
            tx_valid_q   <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q       <= 1'b0;
            cur_last_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_message_q <= tx_message_d;
            grant_q      <= grant_d;
            tx_valid_q   <= tx_valid_d;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q       <= lock_d;
            cur_last_q   <= cur_last_d;
`endif
        end
    end
endmodule
